reg_file_mp: RTL and testbench

- Parametrised, multi-ported successor of the CPU register file.
- Provides N combinational read ports, with same-cycle write forwarding on each.
- Has two write ports: port 0 for the ALU writeback, port 1 for the late/load writeback.
- A per-register busy scoreboard tracks destinations with an outstanding late write. Decode stalls on it.
- Register 0 is hardwired zero. Register OUT_IDX drives the CPU output bus.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/reg_file_mp.sv | 100 ++++++++++
 tb/tb_reg_file_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-ported register file.
package reg_file_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREG_DEF  = 16;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

  typedef enum logic [1:0] {
    FWD_ARRAY,
    FWD_P0,
    FWD_P1,
    FWD_ZERO
  } fwd_sel_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for outstanding late writes, reservation handshake and the
// sticky write-after-write error flag.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [NREG-1:0] busy_vec,
  output logic            rsv_ok,
  output logic            p0_ok,
  output logic            waw_err
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [NREG-1:0] busy_q, busy_d;
  logic            waw_err_q, waw_err_d;
  logic            p1_clr;
  logic            p0_hit_busy;

  always_comb begin
    p1_clr      = we1 && (wa1 != ZERO_A);
    p0_hit_busy = we0 && (wa0 != ZERO_A) && busy_q[wa0];
    p0_ok       = we0 && (wa0 != ZERO_A) && !busy_q[wa0];
    rsv_ok      = rsv_en && ((rsv_addr == ZERO_A) || !busy_q[rsv_addr] ||
                             (we1 && (wa1 == rsv_addr)));

    // Clear first so a same-cycle reservation of the same register wins.
    busy_d = busy_q;
    if (p1_clr)
      busy_d[wa1] = 1'b0;
    if (rsv_ok && (rsv_addr != ZERO_A))
      busy_d[rsv_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;

    waw_err_d = waw_err_q || p0_hit_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      waw_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      waw_err_q <= waw_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign waw_err  = waw_err_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file: NRD forwarded read ports, ALU and late/load
// write ports, busy scoreboard, and an output-bus mirror of one register.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int OUT_IDX = NREG - 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][WIDTH-1:0] rd,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      we0,
  input  logic [AW-1:0]             wa0,
  input  logic [WIDTH-1:0]          wd0,
  input  logic                      we1,
  input  logic [AW-1:0]             wa1,
  input  logic [WIDTH-1:0]          wd1,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic                      rsv_ok,
  output logic [NREG-1:0]           busy_vec,
  output logic                      waw_err,
  output logic [WIDTH-1:0]          cpu_out
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] rf_d [NREG];
  logic             p0_ok;
  fwd_sel_t         fwd_sel [NRD];

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec),
    .rsv_ok   (rsv_ok),
    .p0_ok    (p0_ok),
    .waw_err  (waw_err)
  );

  // Port 1 is applied last so it wins an address collision with port 0.
  always_comb begin
    rf_d = rf_q;
    if (p0_ok)
      rf_d[wa0] = wd0;
    if (we1 && (wa1 != ZERO_A))
      rf_d[wa1] = wd1;
    rf_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      fwd_sel[i] = FWD_ARRAY;
      if (ra[i] == ZERO_A)
        fwd_sel[i] = FWD_ZERO;
      else if (we1 && (wa1 == ra[i]))
        fwd_sel[i] = FWD_P1;
      else if (p0_ok && (wa0 == ra[i]))
        fwd_sel[i] = FWD_P0;

      rd[i] = rf_q[ra[i]];
      case (fwd_sel[i])
        FWD_ZERO:  rd[i] = '0;
        FWD_P1:    rd[i] = wd1;
        FWD_P0:    rd[i] = wd0;
        default:   rd[i] = rf_q[ra[i]];
      endcase

      rd_busy[i] = (ra[i] != ZERO_A) && busy_vec[ra[i]] &&
                   !(we1 && (wa1 == ra[i]));
    end
  end

  assign cpu_out = rf_q[OUT_IDX];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and pseudo-random bench for reg_file_mp against a behavioural model.
module tb_reg_file_mp;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][3:0] ra;
  logic [1:0][7:0] rd;
  logic [1:0]      rd_busy;
  logic            we0, we1, rsv_en;
  logic [3:0]      wa0, wa1, rsv_addr;
  logic [7:0]      wd0, wd1;
  logic            rsv_ok;
  logic [15:0]     busy_vec;
  logic            waw_err;
  logic [7:0]      cpu_out;

  int n_tot  = 0;
  int n_pass = 0;

  reg_file_mp dut (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy_vec),
    .waw_err  (waw_err),
    .cpu_out  (cpu_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents, busy set, sticky error.
  logic [7:0]  m_rf [16];
  logic [15:0] m_busy;
  logic        m_waw;
  bit          m_ok = 1'b0;

  function automatic bit m_p0_taken();
    return we0 && wa0 != 4'd0 && !m_busy[wa0];
  endfunction

  function automatic bit m_rsv_ok();
    return rsv_en && (rsv_addr == 4'd0 || !m_busy[rsv_addr] || (we1 && wa1 == rsv_addr));
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 8'h00;
    if (we1 && wa1 == a) return wd1;
    if (m_p0_taken() && wa0 == a) return wd0;
    return m_rf[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) m_rf[r] = 8'h00;
      m_busy = '0;
      m_waw  = 1'b0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      bit ok_r, p0_t;
      ok_r = m_rsv_ok();
      p0_t = m_p0_taken();
      if (we0 && wa0 != 4'd0 && m_busy[wa0]) m_waw = 1'b1;
      if (p0_t) m_rf[wa0] = wd0;
      if (we1 && wa1 != 4'd0) begin
        m_rf[wa1] = wd1;
        m_busy[wa1] = 1'b0;
      end
      if (ok_r && rsv_addr != 4'd0) m_busy[rsv_addr] = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rd[%0d]", i), 32'(rd[i]), 32'(m_read(ra[i])));
        chk($sformatf("rd_busy[%0d]", i), 32'(rd_busy[i]),
            32'(ra[i] != 4'd0 && m_busy[ra[i]] && !(we1 && wa1 == ra[i])));
      end
      chk("rsv_ok", 32'(rsv_ok), 32'(m_rsv_ok()));
      chk("busy_vec", 32'(busy_vec), 32'(m_busy));
      chk("waw_err", 32'(waw_err), 32'(m_waw));
      chk("cpu_out", 32'(cpu_out), 32'(m_rf[15]));
    end
  end

  task automatic idle();
    reset = 1'b0; ra = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1; we0 = 1'b1; wa0 = 4'd3; wd0 = 8'hAA;
    @(posedge clk); #1;
    reset = 1'b1; we0 = 1'b1; wa0 = 4'd3; wd0 = 8'hAA;
    next();
    ra[0] = 4'd3;
    @(negedge clk);
    chk("lit_r3_after_reset", 32'(rd[0]), 32'h0);
    chk("lit_busy_reset", 32'(busy_vec), 32'h0);
    chk("lit_cpu_out_reset", 32'(cpu_out), 32'h0);
    for (int a = 0; a < 16; a++) begin
      next();
      ra[0] = 4'(a); ra[1] = 4'(15 - a);
    end

    next(); we0 = 1'b1; wa0 = 4'd5; wd0 = 8'h3C; ra[0] = 4'd5;
    @(negedge clk); chk("lit_fwd_p0", 32'(rd[0]), 32'h3C);
    next(); ra[0] = 4'd5;
    @(negedge clk); chk("lit_array_r5", 32'(rd[0]), 32'h3C);

    next(); we0 = 1'b1; wa0 = 4'd7; wd0 = 8'h11; we1 = 1'b1; wa1 = 4'd7; wd1 = 8'h22;
    ra[0] = 4'd7; ra[1] = 4'd7;
    @(negedge clk); chk("lit_collision_fwd", 32'(rd[0]), 32'h22);
    next(); ra[0] = 4'd7;
    @(negedge clk); chk("lit_collision_array", 32'(rd[0]), 32'h22);
    next(); we0 = 1'b1; wa0 = 4'd0; wd0 = 8'hFF; we1 = 1'b1; wa1 = 4'd0; wd1 = 8'hEE;
    @(negedge clk); chk("lit_r0_fwd", 32'(rd[0]), 32'h0);
    next();
    @(negedge clk); chk("lit_r0_array", 32'(rd[0]), 32'h0);

    next(); rsv_en = 1'b1; rsv_addr = 4'd4;
    @(negedge clk); chk("lit_rsv_ok_first", 32'(rsv_ok), 32'h1);
    next(); rsv_en = 1'b1; rsv_addr = 4'd4; ra[0] = 4'd4;
    @(negedge clk);
    chk("lit_busy4_set", 32'(busy_vec[4]), 32'h1);
    chk("lit_rsv_ok_repeat", 32'(rsv_ok), 32'h0);
    chk("lit_rd_busy_r4", 32'(rd_busy[0]), 32'h1);
    next(); we1 = 1'b1; wa1 = 4'd4; wd1 = 8'h5A; rsv_en = 1'b1; rsv_addr = 4'd4; ra[0] = 4'd4;
    @(negedge clk);
    chk("lit_rsv_ok_with_clear", 32'(rsv_ok), 32'h1);
    chk("lit_fwd_p1_r4", 32'(rd[0]), 32'h5A);
    next(); ra[0] = 4'd4;
    @(negedge clk);
    chk("lit_r4_array", 32'(rd[0]), 32'h5A);
    chk("lit_busy4_kept", 32'(busy_vec[4]), 32'h1);
    next(); we1 = 1'b1; wa1 = 4'd4; wd1 = 8'h5B;
    next();
    @(negedge clk); chk("lit_busy4_cleared", 32'(busy_vec[4]), 32'h0);

    next(); rsv_en = 1'b1; rsv_addr = 4'd9;
    next(); we0 = 1'b1; wa0 = 4'd9; wd0 = 8'hFF; ra[0] = 4'd9;
    @(negedge clk);
    chk("lit_p0_busy_no_fwd", 32'(rd[0]), 32'h0);
    chk("lit_waw_not_yet", 32'(waw_err), 32'h0);
    next(); ra[0] = 4'd9;
    @(negedge clk);
    chk("lit_r9_unchanged", 32'(rd[0]), 32'h0);
    chk("lit_waw_set", 32'(waw_err), 32'h1);
    next(); next();
    @(negedge clk); chk("lit_waw_sticky", 32'(waw_err), 32'h1);
    next(); we0 = 1'b1; wa0 = 4'd9; wd0 = 8'h77; we1 = 1'b1; wa1 = 4'd9; wd1 = 8'h66;
    next(); ra[0] = 4'd9;
    @(negedge clk);
    chk("lit_exception_r9", 32'(rd[0]), 32'h66);
    chk("lit_exception_busy9", 32'(busy_vec[9]), 32'h0);
    next(); we1 = 1'b1; wa1 = 4'd2; wd1 = 8'h12;
    next(); ra[0] = 4'd2;
    @(negedge clk);
    chk("lit_p1_nonbusy", 32'(rd[0]), 32'h12);
    chk("lit_busy2_zero", 32'(busy_vec[2]), 32'h0);

    next(); we0 = 1'b1; wa0 = 4'd15; wd0 = 8'h81;
    @(negedge clk); chk("lit_cpu_out_write_cycle", 32'(cpu_out), 32'h0);
    next();
    @(negedge clk); chk("lit_cpu_out_next", 32'(cpu_out), 32'h81);

    next(); reset = 1'b1;
    next();
    @(negedge clk);
    chk("lit_waw_reset", 32'(waw_err), 32'h0);
    chk("lit_cpu_out_reset2", 32'(cpu_out), 32'h0);

    for (int c = 0; c < 400; c++) begin
      next();
      reset    = ($urandom_range(0, 99) == 0);
      ra[0]    = 4'($urandom); ra[1] = 4'($urandom);
      we0      = 1'($urandom); wa0 = 4'($urandom); wd0 = 8'($urandom);
      we1      = ($urandom_range(0, 3) == 0); wa1 = 4'($urandom); wd1 = 8'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0); rsv_addr = 4'($urandom);
      if ($urandom_range(0, 3) == 0) wa0 = 4'd15;
    end
    next(); next();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
